// File: rtl/drp_adc_responder_pkg.sv
// Shared types and constants for the DRP ADC responder: register map, reset values, FSM encodings.
package drp_adc_responder_pkg;

  localparam int unsigned ADDR_W    = 7;
  localparam int unsigned DATA_W    = 16;
  localparam int unsigned CH_W      = 5;
  localparam int unsigned SAMPLE_W  = 12;
  localparam int unsigned NUM_RES   = 8;
  localparam int unsigned RES_IDX_W = 3;

  localparam logic [ADDR_W-1:0] ADDR_RES_BASE = 7'h00;
  localparam logic [ADDR_W-1:0] ADDR_CFG_CH   = 7'h40;
  localparam logic [ADDR_W-1:0] ADDR_CFG_CTRL = 7'h41;
  localparam logic [ADDR_W-1:0] ADDR_THRESH   = 7'h50;

  localparam logic [DATA_W-1:0] RES_RST      = 16'h0000;
  localparam logic [DATA_W-1:0] CFG_CTRL_RST = 16'h0001;
  localparam logic [DATA_W-1:0] THRESH_RST   = 16'hFFF0;

  typedef enum logic [1:0] {
    C_IDLE,
    C_CONV,
    C_DONE
  } conv_state_e;

  typedef enum logic {
    D_IDLE,
    D_WAIT
  } drp_state_e;

  // One captured DRP access
  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
    logic              we;
  } drp_txn_t;

endpackage

// File: rtl/drp_adc_responder_if.sv
// DRP bus between an initiator (master) and the ADC responder (slave).
interface drp_adc_responder_if;
  import drp_adc_responder_pkg::*;

  logic [ADDR_W-1:0] daddr_in;
  logic              den_in;
  logic [DATA_W-1:0] di_in;
  logic              dwe_in;
  logic [DATA_W-1:0] do_out;
  logic              drdy_out;

  modport master (
    output daddr_in, den_in, di_in, dwe_in,
    input  do_out, drdy_out
  );

  modport slave (
    input  daddr_in, den_in, di_in, dwe_in,
    output do_out, drdy_out
  );

endinterface

// File: rtl/drp_adc_responder_regfile.sv
// Register storage for the ADC responder: results, config, write-first read mux.
// THRESH exists only when ADC_ALARM_EN is defined.
module drp_regfile
  import drp_adc_responder_pkg::*;
#(
  parameter logic [CH_W-1:0] RESET_CH = 5'd3
) (
  input  logic              dclk_in,
  input  logic              reset_in,
  input  logic              conv_we,
  input  logic [CH_W-1:0]   conv_ch,
  input  logic [DATA_W-1:0] conv_data,
  input  logic              drp_we,
  input  logic [ADDR_W-1:0] drp_addr,
  input  logic [DATA_W-1:0] drp_wdata,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [DATA_W-1:0] rd_data_c,
  output logic [CH_W-1:0]   cfg_ch,
  output logic              conv_en
`ifdef ADC_ALARM_EN
  ,
  output logic [DATA_W-1:0] thresh
`endif
);

  logic [DATA_W-1:0]    res_q [NUM_RES];
  logic [CH_W-1:0]      cfg_ch_q;
  logic                 conv_en_q;
  logic                 conv_wr_hit_c;
  logic [RES_IDX_W-1:0] conv_idx_c;
  logic [ADDR_W-1:0]    res_off_c;
  logic                 unused_wdata;
`ifdef ADC_ALARM_EN
  logic [DATA_W-1:0]    thresh_q;
  assign thresh = thresh_q;
`endif

  assign conv_wr_hit_c = conv_we && (conv_ch < CH_W'(NUM_RES));
  assign conv_idx_c    = conv_ch[RES_IDX_W-1:0];
  assign cfg_ch        = cfg_ch_q;
  assign conv_en       = conv_en_q;
  assign unused_wdata  = ^drp_wdata[DATA_W-1:CH_W];

  always_ff @(posedge dclk_in) begin
    if (reset_in) begin
      res_q     <= '{default: RES_RST};
      cfg_ch_q  <= RESET_CH;
      conv_en_q <= CFG_CTRL_RST[0];
`ifdef ADC_ALARM_EN
      thresh_q  <= THRESH_RST;
`endif
    end else begin
      if (conv_wr_hit_c) res_q[conv_idx_c] <= conv_data;
      if (drp_we) begin
        case (drp_addr)
          ADDR_CFG_CH:   cfg_ch_q  <= drp_wdata[CH_W-1:0];
          ADDR_CFG_CTRL: conv_en_q <= drp_wdata[0];
`ifdef ADC_ALARM_EN
          ADDR_THRESH:   thresh_q  <= drp_wdata;
`endif
          default: ;
        endcase
      end
    end
  end

  // A conversion result landing in the same cycle wins over the stored value
  always_comb begin
    rd_data_c = '0;
    res_off_c = rd_addr - ADDR_RES_BASE;
    if (res_off_c < ADDR_W'(NUM_RES)) begin
      if (conv_wr_hit_c && (conv_idx_c == res_off_c[RES_IDX_W-1:0])) rd_data_c = conv_data;
      else                                                             rd_data_c = res_q[res_off_c[RES_IDX_W-1:0]];
    end else begin
      case (rd_addr)
        ADDR_CFG_CH:   rd_data_c = DATA_W'(cfg_ch_q);
        ADDR_CFG_CTRL: rd_data_c = DATA_W'(conv_en_q);
`ifdef ADC_ALARM_EN
        ADDR_THRESH:   rd_data_c = thresh_q;
`endif
        default:       rd_data_c = '0;
      endcase
    end
  end

endmodule

// File: rtl/drp_adc_responder.sv
// XADC stand-in: continuous single-channel conversion loop plus a fixed-latency DRP responder.
// Define ADC_ALARM_EN to add the THRESH register and a live alarm_out.
module drp_adc_responder
  import drp_adc_responder_pkg::*;
#(
  parameter int unsigned     CONV_CYCLES = 26,
  parameter int unsigned     DRDY_LAT    = 2,
  parameter logic [CH_W-1:0] RESET_CH    = 5'd3
) (
  input  logic                dclk_in,
  input  logic                reset_in,
  drp_adc_responder_if.slave  drp,
  input  logic [SAMPLE_W-1:0] sample_in,
  output logic                busy_out,
  output logic [CH_W-1:0]     channel_out,
  output logic                eoc_out,
  output logic                eos_out,
  output logic                alarm_out
);

  localparam int unsigned CCNT_W    = $clog2(CONV_CYCLES);
  localparam int unsigned DCNT_W    = $clog2(DRDY_LAT + 1);
  localparam int unsigned CONV_LOAD = CONV_CYCLES - 1;
  localparam int unsigned DRP_LOAD  = (DRDY_LAT > 1) ? DRDY_LAT - 2 : 0;

  conv_state_e       conv_state_q, conv_state_d;
  logic [CCNT_W-1:0] ccnt_q, ccnt_d;
  logic              busy_d, eoc_d, eos_d;
  logic [CH_W-1:0]   channel_d;
  logic              conv_we_c;
  logic [DATA_W-1:0] conv_data_c;

  drp_state_e        dstate_q, dstate_d;
  logic [DCNT_W-1:0] dcnt_q, dcnt_d;
  drp_txn_t          txn_q, txn_d, fire_txn_c;
  logic              fire_c;
  logic              drdy_q, drdy_d;
  logic [DATA_W-1:0] do_q, do_d;

  logic [DATA_W-1:0] rd_data_c;
  logic [CH_W-1:0]   cfg_ch;
  logic              conv_en;
`ifdef ADC_ALARM_EN
  logic [DATA_W-1:0] thresh;
`endif

  assign conv_data_c  = {sample_in, (DATA_W - SAMPLE_W)'(0)};
  assign drp.drdy_out = drdy_q;
  assign drp.do_out   = do_q;

  drp_regfile #(.RESET_CH(RESET_CH)) u_regfile (
    .dclk_in   (dclk_in),
    .reset_in  (reset_in),
    .conv_we   (conv_we_c),
    .conv_ch   (channel_out),
    .conv_data (conv_data_c),
    .drp_we    (fire_c && fire_txn_c.we),
    .drp_addr  (fire_txn_c.addr),
    .drp_wdata (fire_txn_c.data),
    .rd_addr   (fire_txn_c.addr),
    .rd_data_c (rd_data_c),
    .cfg_ch    (cfg_ch),
    .conv_en   (conv_en)
`ifdef ADC_ALARM_EN
    ,
    .thresh    (thresh)
`endif
  );

  always_ff @(posedge dclk_in) begin
    if (reset_in) begin
      conv_state_q <= C_IDLE;
      ccnt_q       <= '0;
      busy_out     <= 1'b0;
      channel_out  <= RESET_CH;
      eoc_out      <= 1'b0;
      eos_out      <= 1'b0;
      dstate_q     <= D_IDLE;
      dcnt_q       <= '0;
      txn_q        <= '0;
      drdy_q       <= 1'b0;
      do_q         <= '0;
    end else begin
      conv_state_q <= conv_state_d;
      ccnt_q       <= ccnt_d;
      busy_out     <= busy_d;
      channel_out  <= channel_d;
      eoc_out      <= eoc_d;
      eos_out      <= eos_d;
      dstate_q     <= dstate_d;
      dcnt_q       <= dcnt_d;
      txn_q        <= txn_d;
      drdy_q       <= drdy_d;
      do_q         <= do_d;
    end
  end

  // Conversion loop; the result is stored on the edge that enters DONE so it is readable alongside eoc
  always_comb begin
    conv_state_d = conv_state_q;
    ccnt_d       = ccnt_q;
    busy_d       = busy_out;
    channel_d    = channel_out;
    eoc_d        = 1'b0;
    eos_d        = 1'b0;
    conv_we_c    = 1'b0;
    case (conv_state_q)
      C_IDLE: begin
        busy_d = 1'b0;
        if (conv_en) begin
          conv_state_d = C_CONV;
          channel_d    = cfg_ch;
          busy_d       = 1'b1;
          ccnt_d       = CCNT_W'(CONV_LOAD);
        end
      end
      C_CONV: begin
        if (ccnt_q == '0) begin
          conv_state_d = C_DONE;
          busy_d       = 1'b0;
          eoc_d        = 1'b1;
          eos_d        = 1'b1;
          conv_we_c    = 1'b1;
        end else begin
          ccnt_d = ccnt_q - CCNT_W'(1);
        end
      end
      C_DONE:  conv_state_d = C_IDLE;
      default: conv_state_d = C_IDLE;
    endcase
  end

  // DRP access: fire_c marks the edge that commits the write / samples read data and raises drdy
  always_comb begin
    dstate_d   = dstate_q;
    dcnt_d     = dcnt_q;
    txn_d      = txn_q;
    fire_c     = 1'b0;
    fire_txn_c = txn_q;
    case (dstate_q)
      D_IDLE: begin
        if (drp.den_in && !drdy_q) begin
          txn_d.addr = drp.daddr_in;
          txn_d.data = drp.di_in;
          txn_d.we   = drp.dwe_in;
          if (DRDY_LAT == 1) begin
            fire_c     = 1'b1;
            fire_txn_c = txn_d;
          end else begin
            dstate_d = D_WAIT;
            dcnt_d   = DCNT_W'(DRP_LOAD);
          end
        end
      end
      D_WAIT: begin
        if (dcnt_q == '0) begin
          fire_c   = 1'b1;
          dstate_d = D_IDLE;
        end else begin
          dcnt_d = dcnt_q - DCNT_W'(1);
        end
      end
      default: dstate_d = D_IDLE;
    endcase
    drdy_d = fire_c;
    do_d   = (fire_c && !fire_txn_c.we) ? rd_data_c : '0;
  end

`ifdef ADC_ALARM_EN
  always_ff @(posedge dclk_in) begin
    if (reset_in)       alarm_out <= 1'b0;
    else if (conv_we_c) alarm_out <= (conv_data_c > thresh);
  end
`else
  assign alarm_out = 1'b0;
`endif

endmodule

// File: tb/tb_drp_adc_responder.sv
// Directed bench for drp_adc_responder: conversion timing, DRP latency, write-first, abort, alarm.
module tb_drp_adc_responder;
  import drp_adc_responder_pkg::*;

  logic                dclk_in = 1'b0;
  logic                reset_in;
  logic [SAMPLE_W-1:0] sample_in;
  logic                busy_out;
  logic [CH_W-1:0]     channel_out;
  logic                eoc_out;
  logic                eos_out;
  logic                alarm_out;

  int n_vec = 0;
  int n_err = 0;

  drp_adc_responder_if drp ();

  drp_adc_responder #(
    .CONV_CYCLES (26),
    .DRDY_LAT    (2),
    .RESET_CH    (5'd3)
  ) dut (
    .dclk_in     (dclk_in),
    .reset_in    (reset_in),
    .drp         (drp),
    .sample_in   (sample_in),
    .busy_out    (busy_out),
    .channel_out (channel_out),
    .eoc_out     (eoc_out),
    .eos_out     (eos_out),
    .alarm_out   (alarm_out)
  );

  always #5 dclk_in = ~dclk_in;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge dclk_in);
    @(negedge dclk_in);
  endtask

  // den in the current cycle; drdy expected exactly two cycles later
  task automatic drp_xfer(input logic [ADDR_W-1:0] addr, input logic we,
                          input logic [DATA_W-1:0] wdata, input logic [DATA_W-1:0] exp,
                          input string tag);
    drp.daddr_in = addr;
    drp.di_in    = wdata;
    drp.dwe_in   = we;
    drp.den_in   = 1'b1;
    tick();
    drp.den_in   = 1'b0;
    drp.dwe_in   = 1'b0;
    check({tag, "_drdy_early"}, 32'(drp.drdy_out), 32'd0);
    check({tag, "_do_early"}, 32'(drp.do_out), 32'd0);
    tick();
    check({tag, "_drdy"}, 32'(drp.drdy_out), 32'd1);
    check({tag, "_do"}, 32'(drp.do_out), 32'(exp));
    tick();
    check({tag, "_drdy_after"}, 32'(drp.drdy_out), 32'd0);
    check({tag, "_do_after"}, 32'(drp.do_out), 32'd0);
  endtask

  // Advance until eoc_out is seen (bounded) and check how many cycles that took
  task automatic wait_eoc(input int exp_cycles, input string tag);
    int n = 0;
    do begin
      tick();
      n++;
    end while (!eoc_out && n < 300);
    check(tag, 32'(n), 32'(exp_cycles));
  endtask

  initial begin
    int n_eoc;
    int n_busy;
    reset_in     = 1'b1;
    sample_in    = 12'hABC;
    drp.daddr_in = '0;
    drp.di_in    = '0;
    drp.dwe_in   = 1'b0;
    drp.den_in   = 1'b0;
    repeat (3) @(posedge dclk_in);
    @(negedge dclk_in);

    check("rst_do", 32'(drp.do_out), 32'd0);
    check("rst_drdy", 32'(drp.drdy_out), 32'd0);
    check("rst_busy", 32'(busy_out), 32'd0);
    check("rst_channel", 32'(channel_out), 32'd3);
    check("rst_eoc", 32'(eoc_out), 32'd0);
    check("rst_eos", 32'(eos_out), 32'd0);
    check("rst_alarm", 32'(alarm_out), 32'd0);

    // Cycle 1 after release is IDLE; DONE (eoc) lands on cycle 28
    reset_in = 1'b0;
    wait_eoc(27, "first_eoc_cycle");
    check("first_eoc_channel", 32'(channel_out), 32'd3);
    check("first_eoc_eos", 32'(eos_out), 32'd1);
    check("first_eoc_busy", 32'(busy_out), 32'd0);
    wait_eoc(28, "eoc_period");

    drp_xfer(7'h03, 1'b0, 16'h0000, 16'hABC0, "rd_res3");

    // Second den one cycle after the first is ignored
    drp.daddr_in = 7'h41;
    drp.dwe_in   = 1'b0;
    drp.den_in   = 1'b1;
    tick();
    check("dbl_drdy_early", 32'(drp.drdy_out), 32'd0);
    drp.daddr_in = 7'h03;
    tick();
    drp.den_in = 1'b0;
    check("dbl_drdy", 32'(drp.drdy_out), 32'd1);
    check("dbl_do_first_addr", 32'(drp.do_out), 32'h0001);
    tick();
    check("dbl_no_extra_1", 32'(drp.drdy_out), 32'd0);
    tick();
    check("dbl_no_extra_2", 32'(drp.drdy_out), 32'd0);

    // CFG_CH change mid-conversion applies to the following conversion
    drp_xfer(ADDR_CFG_CH, 1'b1, 16'h0005, 16'h0000, "wr_cfg_ch5");
    sample_in = 12'h5A5;
    wait_eoc(18, "midconv_eoc_cycle");
    check("midconv_eoc_ch_old", 32'(channel_out), 32'd3);
    wait_eoc(28, "next_eoc_cycle");
    check("next_eoc_ch_new", 32'(channel_out), 32'd5);
    drp_xfer(7'h05, 1'b0, 16'h0000, 16'h5A50, "rd_res5");

    drp_xfer(ADDR_CFG_CH, 1'b1, 16'h0003, 16'h0000, "wr_cfg_ch3");
    drp_xfer(7'h08, 1'b0, 16'h0000, 16'h0000, "rd_res8_zero");
    drp_xfer(ADDR_CFG_CH, 1'b0, 16'h0000, 16'h0003, "rd_cfg_ch");
    drp_xfer(7'h1F, 1'b0, 16'h0000, 16'h0000, "rd_res1f_zero");
    drp_xfer(7'h20, 1'b1, 16'hFFFF, 16'h0000, "wr_unmapped");
    drp_xfer(7'h20, 1'b0, 16'h0000, 16'h0000, "rd_unmapped");
    wait_eoc(7, "eoc_before_wf");
    check("eoc_before_wf_ch", 32'(channel_out), 32'd5);

    // Read of reg 3 whose drdy coincides with the DONE cycle returns the fresh sample
    sample_in = 12'h123;
    repeat (26) tick();
    drp.daddr_in = 7'h03;
    drp.dwe_in   = 1'b0;
    drp.den_in   = 1'b1;
    tick();
    drp.den_in = 1'b0;
    check("wf_drdy_early", 32'(drp.drdy_out), 32'd0);
    tick();
    check("wf_drdy", 32'(drp.drdy_out), 32'd1);
    check("wf_eoc_same_cycle", 32'(eoc_out), 32'd1);
    check("wf_channel", 32'(channel_out), 32'd3);
    check("wf_do_new", 32'(drp.do_out), 32'h1230);
    tick();
    check("wf_drdy_after", 32'(drp.drdy_out), 32'd0);

    // Reset in the middle of an access: no drdy, registers back to reset values
    drp_xfer(ADDR_CFG_CH, 1'b1, 16'h0007, 16'h0000, "wr_cfg_ch7");
    drp.daddr_in = 7'h41;
    drp.den_in   = 1'b1;
    tick();
    drp.den_in = 1'b0;
    reset_in   = 1'b1;
    tick();
    check("abort_drdy", 32'(drp.drdy_out), 32'd0);
    check("abort_do", 32'(drp.do_out), 32'd0);
    check("abort_busy", 32'(busy_out), 32'd0);
    reset_in = 1'b0;
    check("abort_idle_drdy", 32'(drp.drdy_out), 32'd0);
    drp_xfer(ADDR_CFG_CH, 1'b0, 16'h0000, 16'h0003, "rd_cfg_ch_rst");
    drp_xfer(7'h03, 1'b0, 16'h0000, 16'h0000, "rd_res3_rst");
    drp_xfer(ADDR_CFG_CTRL, 1'b0, 16'h0000, 16'h0001, "rd_ctrl_rst");

    // Clearing conv enable mid-CONV: this conversion finishes, none follows
    drp_xfer(ADDR_CFG_CTRL, 1'b1, 16'h0000, 16'h0000, "wr_ctrl_off");
    wait_eoc(15, "last_eoc_cycle");
    n_eoc  = 0;
    n_busy = 0;
    for (int i = 0; i < 60; i++) begin
      tick();
      if (eoc_out)  n_eoc++;
      if (busy_out) n_busy++;
    end
    check("stopped_eoc_count", 32'(n_eoc), 32'd0);
    check("stopped_busy_count", 32'(n_busy), 32'd0);

`ifdef ADC_ALARM_EN
    drp_xfer(ADDR_THRESH, 1'b0, 16'h0000, 16'hFFF0, "rd_thresh_rst");
    drp_xfer(ADDR_THRESH, 1'b1, 16'h8000, 16'h0000, "wr_thresh");
    sample_in = 12'h900;
    drp_xfer(ADDR_CFG_CTRL, 1'b1, 16'h0001, 16'h0000, "wr_ctrl_on");
    wait_eoc(26, "alarm_eoc1_cycle");
    tick();
    check("alarm_high", 32'(alarm_out), 32'd1);
    sample_in = 12'h100;
    wait_eoc(27, "alarm_eoc2_cycle");
    tick();
    check("alarm_low", 32'(alarm_out), 32'd0);
`else
    drp_xfer(ADDR_THRESH, 1'b1, 16'h8000, 16'h0000, "wr_thresh_absent");
    drp_xfer(ADDR_THRESH, 1'b0, 16'h0000, 16'h0000, "rd_thresh_absent");
    sample_in = 12'hFFF;
    drp_xfer(ADDR_CFG_CTRL, 1'b1, 16'h0001, 16'h0000, "wr_ctrl_on");
    wait_eoc(26, "noalarm_eoc_cycle");
    check("noalarm_done", 32'(alarm_out), 32'd0);
    tick();
    check("noalarm_after", 32'(alarm_out), 32'd0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
